btn_bl: RTL and testbench

BTN_BL -- requirements
Module: btn_bl

---
 rtl/btn_bl_pkg.sv | 12 +
 rtl/btn_bl_sync.sv | 22 ++
 rtl/btn_bl.sv | 61 ++++++
 tb/tb_btn_bl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/btn_bl_pkg.sv
// Shared constants and helpers for the btn_bl debouncer.
// Holds the default stability threshold and the counter-width function.
package btn_bl_pkg;

  localparam int STABLE_TICKS_DEF = 4;

  // Width needed to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_bl_sync.sv
// Two-flop synchronizer for the raw button level, with synchronous active-low reset.
// Instantiated by btn_bl only when BTN_BL_SYNC_EN is defined.
module btn_bl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_bl.sv
// Button debouncer: EN follows BTN once it is stable for STABLE_TICKS sample ticks; RES pulses on press.
// Optional input synchronizer enabled by defining BTN_BL_SYNC_EN.
module btn_bl
  import btn_bl_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic BTN,
  output logic EN,
  output logic RES
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          ce_d;
  logic          tick;
  logic          s;
  logic [CW-1:0] cnt;

`ifdef BTN_BL_SYNC_EN
  btn_bl_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (BTN),
    .q     (s)
  );
`else
  assign s = BTN;
`endif

  assign tick = ce & ~ce_d;

  // RES is registered alongside EN so it is high for the clk after a 0->1 acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_d <= 1'b0;
      EN   <= 1'b0;
      RES  <= 1'b0;
      cnt  <= '0;
    end else begin
      ce_d <= ce;
      RES  <= 1'b0;
      if (tick) begin
        if (s == EN) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          EN  <= ~EN;
          RES <= ~EN;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_bl.sv
// Self-checking bench for btn_bl (STABLE_TICKS = 4): tick-level vector table with scoreboard
// plus hand-written reset, ce-hold and repeated-toggle sequences.
module tb_btn_bl;

  logic clk;
  logic rst_n;
  logic ce;
  logic BTN;
  logic EN;
  logic RES;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic btn;
    logic en;
    logic res;
  } vec_t;

  typedef struct {
    logic en;
    int   res_cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  btn_bl #(.STABLE_TICKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .BTN   (BTN),
    .EN    (EN),
    .RES   (RES)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic b, input logic e, input logic r, input int n = 1);
    vec_t v;
    v.btn = b;
    v.en  = e;
    v.res = r;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // One sample tick: 4 clk (8 ns), BTN settles 2 clk before ce rises. Call at a negedge.
  task automatic do_tick(input logic b, output int rc, output logic en_o);
    BTN = b;
    ce  = 1'b0;
    rc  = 0;
    repeat (2) begin @(posedge clk); @(negedge clk); rc += int'(RES); end
    ce = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); rc += int'(RES); end
    en_o = EN;
  endtask

  task automatic tick_check(input string name, input logic b, input logic e, input logic r);
    int   rc;
    logic en_o;
    exp_t x;
    x.en      = e;
    x.res_cnt = int'(r);
    sb.push_back(x);
    do_tick(b, rc, en_o);
    x = sb.pop_front();
    check({name, "_en"}, int'(en_o), int'(x.en));
    check({name, "_res"}, rc, x.res_cnt);
  endtask

  initial begin
    int   rc;
    int   res_total;
    logic en_o;
    logic lvl;
    logic prev;

    rst_n = 1'b0;
    ce    = 1'b0;
    BTN   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held 3 clk with BTN=1 and ce toggling (reset beats the tick).
    BTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ce = ~ce;
      @(posedge clk); @(negedge clk);
      check("reset_en", int'(EN), 0);
      check("reset_res", int'(RES), 0);
    end
    ce    = 1'b0;
    rst_n = 1'b1;

    // Tick-level table, starting right after reset release with BTN held 1.
    add(1, 0, 0, 3); add(1, 1, 1); add(1, 1, 0, 8);          // clean press
    add(0, 1, 0, 3); add(0, 0, 0); add(0, 0, 0, 8);          // clean release
    add(1, 0, 0, 2); add(0, 0, 0); add(1, 0, 0, 3);          // bounced press
    add(1, 1, 1); add(1, 1, 0, 2);
    add(0, 1, 0, 2); add(1, 1, 0); add(0, 1, 0, 3);          // bounced release
    add(0, 0, 0); add(0, 0, 0, 2);
    add(1, 0, 0, 3); add(0, 0, 0, 4);                        // 3-tick glitch
    foreach (vecs[i]) tick_check($sformatf("vec%0d", i), vecs[i].btn, vecs[i].en, vecs[i].res);

    // Reset in mid-count discards the count.
    tick_check("midrst_a", 1, 0, 0);
    tick_check("midrst_b", 1, 0, 0);
    ce    = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_en", int'(EN), 0);
    check("midrst_res", int'(RES), 0);
    rst_n = 1'b1;
    ce    = 1'b0;
    @(posedge clk); @(negedge clk);
    tick_check("midrst_c", 1, 0, 0);
    tick_check("midrst_d", 1, 0, 0);
    tick_check("midrst_e", 1, 0, 0);
    tick_check("midrst_f", 1, 1, 1);
    tick_check("midrst_g", 1, 1, 0);

    // ce held constant for 200 ns (high, then low) while BTN wanders: EN must hold.
    tick_check("hold_pre", 1, 1, 0);
    for (int i = 0; i < 100; i++) begin
      BTN = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      check("hold_hi_en", int'(EN), 1);
    end
    BTN = 1'b1;
    ce  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      BTN = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      check("hold_lo_en", int'(EN), 1);
    end
    tick_check("hold_post", 1, 1, 0);
    tick_check("rel_a", 0, 1, 0);
    tick_check("rel_b", 0, 1, 0);
    tick_check("rel_c", 0, 1, 0);
    tick_check("rel_d", 0, 0, 0);

    // BTN toggled every ~100 ns (12 ticks), 10 times: EN follows 4 ticks later, 5 RES pulses.
    res_total = 0;
    prev      = 1'b0;
    for (int k = 0; k < 10; k++) begin
      lvl = (k % 2 == 0);
      for (int t = 0; t < 12; t++) begin
        do_tick(lvl, rc, en_o);
        res_total += rc;
        check($sformatf("tog%0d_%0d_en", k, t), int'(en_o), int'((t < 3) ? prev : lvl));
        check($sformatf("tog%0d_%0d_res", k, t), rc, int'((t == 3) && lvl));
      end
      prev = lvl;
    end
    check("tog_res_total", res_total, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
